// File: rtl/uart_cmd_parser.sv
// Line-oriented command parser between a UART RX FIFO and TX FIFO.
// Accepts two hex digits plus CR, echoes input and answers 'K' or '?'.
module uart_cmd_parser #(
    parameter int unsigned ECHO = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_empty,
    input  logic [7:0] r_data,
    output logic       rd_uart,
    input  logic       tx_full,
    output logic       wr_uart,
    output logic [7:0] w_data,
    output logic [7:0] value,
    output logic       value_valid,
    output logic [7:0] err_cnt
);

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned NIB_W   = 4;
    localparam logic        ECHO_EN = (ECHO != 0);

    localparam logic [BYTE_W-1:0] CH_CR = 8'h0D;
    localparam logic [BYTE_W-1:0] CH_LF = 8'h0A;
    localparam logic [BYTE_W-1:0] CH_OK = 8'h4B;
    localparam logic [BYTE_W-1:0] CH_NG = 8'h3F;
    localparam logic [BYTE_W-1:0] CNT_MAX = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LO    = 3'd1,
        ST_TERM  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [NIB_W-1:0]    hi_q, hi_d;
    logic [NIB_W-1:0]    lo_q, lo_d;
    logic [BYTE_W-1:0]   resp_q, resp_d;
    logic [BYTE_W-1:0]   value_q, value_d;
    logic                vvalid_q, vvalid_d;
    logic [BYTE_W-1:0]   err_q, err_d;
    logic [NIB_W:0]      hex;
    logic                can_read;

    // Returns {is_hex, nibble}; nibble is zero for non-hex bytes.
    function automatic logic [NIB_W:0] hex_decode(input logic [BYTE_W-1:0] c);
        logic [NIB_W:0] r;
        r = '0;
        if (c >= 8'h30 && c <= 8'h39) begin
            r = {1'b1, NIB_W'(c - 8'h30)};
        end else if (c >= 8'h41 && c <= 8'h46) begin
            r = {1'b1, NIB_W'(c - 8'h37)};
        end else if (c >= 8'h61 && c <= 8'h66) begin
            r = {1'b1, NIB_W'(c - 8'h57)};
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            hi_q     <= '0;
            lo_q     <= '0;
            resp_q   <= '0;
            value_q  <= '0;
            vvalid_q <= 1'b0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            resp_q   <= resp_d;
            value_q  <= value_d;
            vvalid_q <= vvalid_d;
            err_q    <= err_d;
        end
    end

    // Strobes are combinational so a pop/push lands on the edge that consumes the byte.
    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        resp_d   = resp_q;
        value_d  = value_q;
        vvalid_d = 1'b0;
        err_d    = err_q;
        rd_uart  = 1'b0;
        wr_uart  = 1'b0;
        w_data   = '0;
        hex      = hex_decode(r_data);
        can_read = reset && !rx_empty && (!ECHO_EN || !tx_full);

        case (state_q)
            ST_RESP: begin
                if (reset && !tx_full) begin
                    wr_uart = 1'b1;
                    w_data  = resp_q;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                if (can_read) begin
                    rd_uart = 1'b1;
                    if (ECHO_EN) begin
                        wr_uart = 1'b1;
                        w_data  = r_data;
                    end
                    case (state_q)
                        ST_IDLE: begin
                            if (hex[NIB_W]) begin
                                hi_d    = hex[NIB_W-1:0];
                                state_d = ST_LO;
                            end else if (r_data != CH_CR && r_data != CH_LF) begin
                                state_d = ST_FLUSH;
                            end
                        end
                        ST_LO: begin
                            if (hex[NIB_W]) begin
                                lo_d    = hex[NIB_W-1:0];
                                state_d = ST_TERM;
                            end else if (r_data == CH_CR) begin
                                resp_d  = CH_NG;
                                err_d   = (err_q == CNT_MAX) ? err_q : err_q + 8'd1;
                                state_d = ST_RESP;
                            end else begin
                                state_d = ST_FLUSH;
                            end
                        end
                        ST_TERM: begin
                            if (r_data == CH_CR) begin
                                value_d  = {hi_q, lo_q};
                                vvalid_d = 1'b1;
                                resp_d   = CH_OK;
                                state_d  = ST_RESP;
                            end else begin
                                state_d = ST_FLUSH;
                            end
                        end
                        ST_FLUSH: begin
                            if (r_data == CH_CR) begin
                                resp_d  = CH_NG;
                                err_d   = (err_q == CNT_MAX) ? err_q : err_q + 8'd1;
                                state_d = ST_RESP;
                            end
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
        endcase
    end

    assign value       = value_q;
    assign value_valid = vvalid_q;
    assign err_cnt     = err_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench: a line-level reference model predicts the TX byte stream,
// value updates and error count; a monitor checks what the parser produces.
module tb_uart_cmd_parser;

    localparam int unsigned ECHO_TB = 1;
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_empty = 1'b1;
    logic [7:0] r_data = 8'h00;
    logic       rd_uart;
    logic       tx_full = 1'b0;
    logic       wr_uart;
    logic [7:0] w_data;
    logic [7:0] value;
    logic       value_valid;
    logic [7:0] err_cnt;

    int checks = 0;
    int failures = 0;

    logic [7:0] rxq[$];
    logic [7:0] exp_tx[$];
    logic [7:0] exp_val[$];
    logic [7:0] line_buf[$];
    int         model_err = 0;
    logic [7:0] model_value = 8'h00;

    int unsigned full_pct = 0;
    int unsigned hold_pct = 0;
    logic        force_full = 1'b0;
    logic        rx_hold;

    uart_cmd_parser #(.ECHO(ECHO_TB)) dut (
        .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data),
        .rd_uart(rd_uart), .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data),
        .value(value), .value_valid(value_valid), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic bit is_hex(input logic [7:0] c);
        return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46) ||
               (c >= 8'h61 && c <= 8'h66);
    endfunction

    function automatic logic [3:0] hexval(input logic [7:0] c);
        if (c <= 8'h39) return 4'(c - 8'h30);
        if (c <= 8'h46) return 4'(c - 8'h41 + 8'd10);
        return 4'(c - 8'h61 + 8'd10);
    endfunction

    // Whole-line rule: leading LFs are skipped, an empty line is silent,
    // exactly two hex digits is accepted, anything else is rejected.
    task automatic push_line();
        int start;
        int seglen;
        logic [7:0] v;
        line_buf.push_back(CR);
        foreach (line_buf[i]) begin
            rxq.push_back(line_buf[i]);
            if (ECHO_TB != 0) exp_tx.push_back(line_buf[i]);
        end
        start = 0;
        while (start < line_buf.size() - 1 && line_buf[start] == LF) start++;
        seglen = line_buf.size() - 1 - start;
        if (seglen == 2 && is_hex(line_buf[start]) && is_hex(line_buf[start+1])) begin
            v = {hexval(line_buf[start]), hexval(line_buf[start+1])};
            exp_tx.push_back(8'h4B);
            exp_val.push_back(v);
            model_value = v;
        end else if (seglen > 0) begin
            exp_tx.push_back(8'h3F);
            if (model_err < 255) model_err++;
        end
        line_buf.delete();
    endtask

    function automatic logic [7:0] rand_hex();
        int unsigned v;
        v = $urandom_range(15);
        if (v < 10) return 8'(8'h30 + v);
        return ($urandom_range(1) == 1) ? 8'(8'h41 + v - 10) : 8'(8'h61 + v - 10);
    endfunction

    function automatic logic [7:0] rand_noncr();
        logic [7:0] b;
        b = 8'($urandom_range(255));
        if (b == CR) b = 8'h5A;
        return b;
    endfunction

    task automatic gen_random_line();
        int unsigned kind;
        int unsigned n;
        kind = $urandom_range(7);
        case (kind)
            0, 1, 2: begin line_buf.push_back(rand_hex()); line_buf.push_back(rand_hex()); end
            3: line_buf.push_back(rand_hex());
            4: repeat (3) line_buf.push_back(rand_hex());
            5: begin
                if ($urandom_range(1) == 1) begin
                    line_buf.push_back(8'h47); line_buf.push_back(rand_hex());
                end else begin
                    line_buf.push_back(rand_hex()); line_buf.push_back(rand_noncr());
                end
            end
            6: begin
                n = $urandom_range(2);
                repeat (n) line_buf.push_back(LF);
                if ($urandom_range(1) == 1) begin
                    line_buf.push_back(rand_hex()); line_buf.push_back(rand_hex());
                end
            end
            default: begin
                n = $urandom_range(4);
                repeat (n) begin
                    case ($urandom_range(3))
                        0: line_buf.push_back(rand_hex());
                        1: line_buf.push_back(LF);
                        default: line_buf.push_back(rand_noncr());
                    endcase
                end
            end
        endcase
        push_line();
    endtask

    task automatic drain();
        int i;
        i = 0;
        while (i < 20000 && !(rxq.size() == 0 && exp_tx.size() == 0)) begin
            @(posedge clk);
            i++;
        end
        check("drain_done", 32'(rxq.size() + exp_tx.size()), 32'd0);
        repeat (3) @(posedge clk);
        check("value_pending", 32'(exp_val.size()), 32'd0);
        check("err_cnt", 32'(err_cnt), 32'(model_err));
        check("value", 32'(value), 32'(model_value));
    endtask

    // RX FIFO model and TX back-pressure; the queue pops when the parser strobes.
    initial begin
        logic [7:0] dummy;
        forever begin
            @(negedge clk);
            tx_full  = force_full || ($urandom_range(99) < full_pct);
            rx_hold  = ($urandom_range(99) < hold_pct);
            rx_empty = (rxq.size() == 0) || rx_hold;
            r_data   = rx_empty ? 8'h00 : rxq[0];
            #1;
            if (rd_uart) begin
                check("rd_while_empty", 32'(rx_empty), 32'd0);
                if (ECHO_TB != 0) check("echo_same_cycle", {23'd0, wr_uart, w_data}, {23'd0, 1'b1, r_data});
                if (!rx_empty) dummy = rxq.pop_front();
            end
        end
    end

    // Monitor: compares every TX push and value update against the scoreboard.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (wr_uart) begin
                check("wr_while_full", 32'(tx_full), 32'd0);
                if (exp_tx.size() == 0) begin
                    check("tx_unexpected", 32'(w_data), 32'h100);
                end else begin
                    e = exp_tx.pop_front();
                    check("tx_byte", 32'(w_data), 32'(e));
                end
            end
            if (value_valid) begin
                if (exp_val.size() == 0) begin
                    check("vvalid_unexpected", 32'(value), 32'h100);
                end else begin
                    e = exp_val.pop_front();
                    check("value_update", 32'(value), 32'(e));
                end
            end
        end
    end

    initial begin
        int i;
        // Reset with a line already waiting: nothing may be popped.
        line_buf.push_back(8'h33); line_buf.push_back(8'h46);
        push_line();
        repeat (3) @(negedge clk);
        #3;
        check("rst_rd_uart", 32'(rd_uart), 32'd0);
        check("rst_wr_uart", 32'(wr_uart), 32'd0);
        check("rst_w_data", 32'(w_data), 32'd0);
        check("rst_value", 32'(value), 32'd0);
        check("rst_value_valid", 32'(value_valid), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #2;
        check("first_read_after_rst", 32'(rd_uart), 32'd1);
        drain();

        // Directed lines: lower-case, bad first digit, too long.
        line_buf.push_back(8'h61); line_buf.push_back(8'h62); push_line();
        line_buf.push_back(8'h47); line_buf.push_back(8'h31); push_line();
        line_buf.push_back(8'h31); line_buf.push_back(8'h32); line_buf.push_back(8'h33); push_line();
        drain();

        // TX full holds a waiting byte back; release pops and echoes together.
        force_full = 1'b1;
        @(negedge clk);
        @(posedge clk);
        line_buf.push_back(8'h34); line_buf.push_back(8'h35); push_line();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #3;
            check("stall_no_read", {30'd0, rd_uart, wr_uart}, 32'd0);
        end
        force_full = 1'b0;
        @(negedge clk);
        #3;
        check("stall_release", {22'd0, rd_uart, wr_uart, w_data}, {22'd0, 1'b1, 1'b1, 8'h34});
        drain();

        // Randomized lines under random RX gaps and TX back-pressure.
        full_pct = 30;
        hold_pct = 20;
        for (int k = 0; k < 200; k++) begin
            gen_random_line();
            if ($urandom_range(3) == 0) repeat ($urandom_range(6)) @(posedge clk);
        end
        drain();

        // Reset after a partial command has been consumed.
        rxq.push_back(8'h31);
        if (ECHO_TB != 0) exp_tx.push_back(8'h31);
        i = 0;
        while (i < 2000 && rxq.size() != 0) begin
            @(posedge clk);
            i++;
        end
        check("partial_popped", 32'(rxq.size()), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_err = 0;
        model_value = 8'h00;
        exp_val.delete();
        #3;
        check("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        line_buf.push_back(8'h32); line_buf.push_back(8'h33); push_line();
        drain();

        // Error counter saturation.
        for (int k = 0; k < 259; k++) begin
            line_buf.push_back(8'h47);
            push_line();
        end
        drain();
        check("err_saturated", 32'(err_cnt), 32'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 Parameter ECHO, default 1: when 1, every consumed RX byte is written back to the TX FIFO; when 0, no echo.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; 0 forces reset state immediately.
REQ-004 rx_empty  input  1  UART RX FIFO empty flag.
REQ-005 r_data  input  8  UART RX FIFO head byte, valid whenever rx_empty=0.
REQ-006 rd_uart  output  1  one-cycle pop strobe to the RX FIFO.
REQ-007 tx_full  input  1  UART TX FIFO full flag.
REQ-008 wr_uart  output  1  one-cycle push strobe to the TX FIFO.
REQ-009 w_data  output  8  byte pushed to the TX FIFO, valid when wr_uart=1.
REQ-010 value  output  8  last successfully parsed command byte.
REQ-011 value_valid  output  1  one-cycle pulse when value updates.
REQ-012 err_cnt  output  8  saturating count of rejected command lines.

Function
REQ-013 Command format: exactly two ASCII hex digits (0-9, A-F, a-f), high nibble first, then CR (0x0D).
REQ-014 States: IDLE (await high digit), LO (await low digit), TERM (await CR), FLUSH (discard to CR after error), RESP (send response byte).
REQ-015 Read rule: in IDLE/LO/TERM/FLUSH, rd_uart=1 for one cycle when rx_empty=0 and (ECHO=0 or tx_full=0); byte is r_data sampled in that cycle; no read in RESP.
REQ-016 Echo: with ECHO=1, wr_uart=1 and w_data=r_data in the same cycle as rd_uart.
REQ-017 IDLE: hex digit -> store high nibble, go LO; CR or LF (0x0A) -> ignore, stay IDLE; any other byte -> FLUSH.
REQ-018 LO: hex digit -> store low nibble, go TERM; CR -> response code '?' (0x3F), go RESP; other -> FLUSH.
REQ-019 TERM: CR -> value <= {high,low}, value_valid=1 next cycle, response code 'K' (0x4B), go RESP; any other byte -> FLUSH.
REQ-020 FLUSH: consume and discard (echo still applies) until CR, then response code '?', go RESP.
REQ-021 Every rejected line increments err_cnt by 1 when its '?' is queued; err_cnt saturates at 255, no wrap.
REQ-022 RESP: wait while tx_full=1; first cycle with tx_full=0 -> wr_uart=1, w_data=response code, go IDLE.
REQ-023 Latency: value and value_valid update in the cycle after the CR pop; response push no earlier than the cycle after the CR pop.
REQ-024 value holds its old value on any rejected line; value_valid never asserts on a rejected line.
REQ-025 rd_uart and wr_uart are never asserted in two consecutive cycles by the same byte; no read while RX empty, no write while TX full.
REQ-026 Hex decode: '0'-'9' -> 0-9, 'A'-'F' and 'a'-'f' -> 10-15.

Reset
REQ-027 While reset=0: state IDLE, rd_uart=0, wr_uart=0, w_data=0x00, value=0x00, value_valid=0, err_cnt=0, stored nibbles 0.
REQ-028 Reset mid-command discards partial command and any pending response; no strobe issued in reset cycle.
REQ-029 First read permitted in the first rising edge after reset returns to 1.

Verification
REQ-030 ECHO=1, tx_full=0, RX "3","F",CR -> TX bytes 0x33,0x46,0x0D,0x4B; value=0x3F; one value_valid pulse; err_cnt=0.
REQ-031 RX "a","b",CR -> value=0xAB; response 0x4B.
REQ-032 RX "G","1",CR -> TX 0x47,0x31,0x0D,0x3F; value unchanged; err_cnt=1; no value_valid.
REQ-033 RX "1","2","3",CR -> FLUSH on '3'; response 0x3F; err_cnt+1; value unchanged.
REQ-034 ECHO=1, byte waiting, tx_full=1 for 10 cycles -> rd_uart stays 0; tx_full=0 -> pop and echo same cycle.
REQ-035 Reset pulse after "1" popped, then "2","3",CR -> value=0x23, err_cnt=0; 256 bad lines -> err_cnt=255.
